// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPU and video.
// Each access takes four cycles: grant, issue, wait, ack.
module spram_arbiter #(
   parameter int AW = 6,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_dout,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [DW-1:0] vid_dout,
   output logic          ram_ce,
   output logic          ram_oce,
   output logic          ram_wre,
   output logic [AW-1:0] ram_ad,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t        state_q, state_d;
   logic          gnt_vid_q, gnt_vid_d;
   logic          last_vid_q, last_vid_d;
   logic          we_q, we_d;
   logic          gnt;
   logic          cpu_ack_d, vid_ack_d;
   logic          ram_ce_d, ram_wre_d;
   logic [AW-1:0] ram_ad_d;
   logic [DW-1:0] ram_din_d;
   logic [DW-1:0] cpu_dout_d, vid_dout_d;

   assign ram_oce = 1'b1;

   always_comb begin
      state_d    = state_q;
      gnt_vid_d  = gnt_vid_q;
      last_vid_d = last_vid_q;
      we_d       = we_q;
      gnt        = 1'b0;
      cpu_ack_d  = 1'b0;
      vid_ack_d  = 1'b0;
      ram_ce_d   = ram_ce;
      ram_wre_d  = ram_wre;
      ram_ad_d   = ram_ad;
      ram_din_d  = ram_din;
      cpu_dout_d = cpu_dout;
      vid_dout_d = vid_dout;
      unique case (state_q)
         IDLE: begin
            if (cpu_req || vid_req) begin
               // On a tie, the side not served last wins
               gnt        = (cpu_req && vid_req) ? ~last_vid_q : vid_req;
               gnt_vid_d  = gnt;
               last_vid_d = gnt;
               we_d       = ~gnt & cpu_we;
               ram_ce_d   = 1'b1;
               ram_wre_d  = ~gnt & cpu_we;
               ram_ad_d   = gnt ? vid_addr : cpu_addr;
               if (~gnt & cpu_we)
                  ram_din_d = cpu_din;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            ram_ce_d  = 1'b0;
            ram_wre_d = 1'b0;
            state_d   = WAIT;
         end
         WAIT: begin
            if (!we_q) begin
               if (gnt_vid_q) vid_dout_d = ram_dout;
               else           cpu_dout_d = ram_dout;
            end
            if (gnt_vid_q) vid_ack_d = 1'b1;
            else           cpu_ack_d = 1'b1;
            state_d = ACK;
         end
         ACK: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_vid_q  <= 1'b0;
         last_vid_q <= 1'b1;
         we_q       <= 1'b0;
         cpu_ack    <= 1'b0;
         vid_ack    <= 1'b0;
         ram_ce     <= 1'b0;
         ram_wre    <= 1'b0;
         ram_ad     <= '0;
         ram_din    <= '0;
         cpu_dout   <= '0;
         vid_dout   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_vid_q  <= gnt_vid_d;
         last_vid_q <= last_vid_d;
         we_q       <= we_d;
         cpu_ack    <= cpu_ack_d;
         vid_ack    <= vid_ack_d;
         ram_ce     <= ram_ce_d;
         ram_wre    <= ram_wre_d;
         ram_ad     <= ram_ad_d;
         ram_din    <= ram_din_d;
         cpu_dout   <= cpu_dout_d;
         vid_dout   <= vid_dout_d;
      end
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural bypass-mode SPRAM.
// Inputs change and outputs are sampled on the falling edge.
module tb_spram_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_din = '0;
   logic          cpu_ack;
   logic [DW-1:0] cpu_dout;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic          vid_ack;
   logic [DW-1:0] vid_dout;
   logic          ram_ce, ram_oce, ram_wre;
   logic [AW-1:0] ram_ad;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_wre) mem[ram_ad] <= ram_din;
         else         ram_dout <= mem[ram_ad];
      end
   end

   spram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
      .vid_dout(vid_dout),
      .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
      .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, output int lat,
                             output int wre_cnt, output bit ok);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
      lat = 0; wre_cnt = 0; ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         lat++;
         if (ram_wre) wre_cnt++;
         if (cpu_ack) begin ok = 1'b1; break; end
      end
      cpu_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({cpu_ack, vid_ack, ram_ce, ram_wre, ram_oce} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b want 00001",
                  {cpu_ack, vid_ack, ram_ce, ram_wre, ram_oce});
      end
      n_tests++;
      if ({ram_ad, ram_din, cpu_dout, vid_dout} !== '0) begin
         n_fail++;
         $display("FAIL reset_data got ad=%h din=%h cd=%h vd=%h want 0",
                  ram_ad, ram_din, cpu_dout, vid_dout);
      end
   endtask

   task automatic test_write_read();
      int lat, wc;
      bit ok;
      cpu_access(1'b1, 6'h05, 8'hA7, lat, wc, ok);
      n_tests++;
      if (!ok || lat != 3 || wc != 1) begin
         n_fail++;
         $display("FAIL wr_timing got ok=%0d lat=%0d wre=%0d want 1/3/1",
                  ok, lat, wc);
      end
      n_tests++;
      if (cpu_dout !== 8'h00) begin
         n_fail++;
         $display("FAIL wr_dout_hold got %h want 00", cpu_dout);
      end
      cpu_access(1'b0, 6'h05, 8'hFF, lat, wc, ok);
      n_tests++;
      if (!ok || lat != 3 || wc != 0 || cpu_dout !== 8'hA7) begin
         n_fail++;
         $display("FAIL rd_back got ok=%0d lat=%0d wre=%0d dout=%h want 1/3/0/a7",
                  ok, lat, wc, cpu_dout);
      end
   endtask

   task automatic test_vid_read();
      int lat, wc, cack;
      bit ok;
      cpu_access(1'b1, 6'h3F, 8'h5C, lat, wc, ok);
      @(negedge clk);
      vid_req = 1'b1; vid_addr = 6'h3F;
      ok = 1'b0; cack = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (cpu_ack) cack++;
         if (vid_ack) begin ok = 1'b1; break; end
      end
      vid_req = 1'b0;
      n_tests++;
      if (!ok || vid_dout !== 8'h5C) begin
         n_fail++;
         $display("FAIL vid_read got ok=%0d dout=%h want 1/5c", ok, vid_dout);
      end
      n_tests++;
      if (cack != 0 || cpu_dout !== 8'hA7) begin
         n_fail++;
         $display("FAIL vid_cpu_quiet got acks=%0d dout=%h want 0/a7",
                  cack, cpu_dout);
      end
   endtask

   task automatic test_drop_req();
      int acks;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h3F;
      @(negedge clk);
      @(negedge clk);
      cpu_req = 1'b0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cpu_ack) acks++;
      end
      n_tests++;
      if (acks != 1 || cpu_dout !== 8'h5C || ram_ce !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_req got acks=%0d dout=%h ce=%b want 1/5c/0",
                  acks, cpu_dout, ram_ce);
      end
   endtask

   task automatic test_reset_wait();
      int vack;
      bit ok;
      @(negedge clk);
      vid_req = 1'b1; vid_addr = 6'h05;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      vack = 0;
      @(negedge clk);
      if (vid_ack) vack++;
      n_tests++;
      if (vack != 0 || {cpu_ack, ram_ce, ram_wre, ram_oce} !== 4'b0001 ||
          {ram_ad, ram_din, cpu_dout, vid_dout} !== '0) begin
         n_fail++;
         $display("FAIL rst_in_wait got vack=%0d ctl=%b ad=%h din=%h cd=%h vd=%h want 0/0001/0",
                  vack, {cpu_ack, ram_ce, ram_wre, ram_oce},
                  ram_ad, ram_din, cpu_dout, vid_dout);
      end
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (vid_ack) break;
         if (cpu_ack) begin ok = 1'b1; break; end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      n_tests++;
      if (!ok || cpu_dout !== 8'hA7) begin
         n_fail++;
         $display("FAIL rst_tie_cpu got cpu_first=%0d dout=%h want 1/a7",
                  ok, cpu_dout);
      end
   endtask

   task automatic test_alternate();
      logic seq [0:3];
      int   n, overlap;
      @(negedge clk);
      reset = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'h05;
      vid_req = 1'b1; vid_addr = 6'h3F;
      @(negedge clk);
      reset = 1'b0;
      n = 0; overlap = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (cpu_ack && vid_ack) overlap++;
         if (cpu_ack || vid_ack) begin
            seq[n] = vid_ack;
            n++;
         end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      n_tests++;
      if (n != 4 || overlap != 0) begin
         n_fail++;
         $display("FAIL alt_count got grants=%0d overlap=%0d want 4/0",
                  n, overlap);
      end
      n_tests++;
      if ({seq[0], seq[1], seq[2], seq[3]} !== 4'b0101) begin
         n_fail++;
         $display("FAIL alt_order got %b want 0101 (1=vid)",
                  {seq[0], seq[1], seq[2], seq[3]});
      end
      n_tests++;
      if (cpu_dout !== 8'hA7 || vid_dout !== 8'h5C) begin
         n_fail++;
         $display("FAIL alt_data got cd=%h vd=%h want a7/5c",
                  cpu_dout, vid_dout);
      end
   endtask

   task automatic concurrent(output logic vid_first,
                             output logic [DW-1:0] vd, output bit ok);
      bit cdone, vdone;
      int overlap;
      cdone = 0; vdone = 0; overlap = 0; vid_first = 1'b0; vd = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'h00; cpu_din = 8'h11;
      vid_req = 1'b1; vid_addr = 6'h00;
      for (int i = 0; i < 20 && !(cdone && vdone); i++) begin
         @(negedge clk);
         if (cpu_ack && vid_ack) overlap++;
         if (cpu_ack) begin cpu_req = 1'b0; cdone = 1; end
         if (vid_ack) begin
            vid_req = 1'b0; vd = vid_dout; vdone = 1;
            vid_first = !cdone;
         end
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      ok = cdone && vdone && overlap == 0;
   endtask

   task automatic test_concurrent();
      int lat, wc;
      bit ok;
      logic vf;
      logic [DW-1:0] vd;
      cpu_access(1'b0, 6'h05, 8'h00, lat, wc, ok);
      cpu_access(1'b1, 6'h00, 8'h22, lat, wc, ok);
      concurrent(vf, vd, ok);
      n_tests++;
      if (!ok || vf !== 1'b1 || vd !== 8'h22) begin
         n_fail++;
         $display("FAIL conc_vid_first got ok=%0d vfirst=%b vd=%h want 1/1/22",
                  ok, vf, vd);
      end
      cpu_access(1'b1, 6'h00, 8'h22, lat, wc, ok);
      do_reset();
      concurrent(vf, vd, ok);
      n_tests++;
      if (!ok || vf !== 1'b0 || vd !== 8'h11) begin
         n_fail++;
         $display("FAIL conc_cpu_first got ok=%0d vfirst=%b vd=%h want 1/0/11",
                  ok, vf, vd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_vid_read();
      test_drop_req();
      test_reset_wait();
      test_alternate();
      test_concurrent();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 Parameters (name, default, meaning), none overridden in normal builds: AW, 6, RAM address width; DW, 8, RAM data width.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 cpu_req  in  1  CPU access request, held high until cpu_ack seen.
REQ-006 cpu_we  in  1  1 = write, 0 = read, stable while cpu_req high.
REQ-007 cpu_addr  in  AW  CPU word address.
REQ-008 cpu_din  in  DW  CPU write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse.
REQ-010 cpu_dout  out  DW  CPU read data, valid with cpu_ack.
REQ-011 vid_req  in  1  video sprite-scan read request, same hold rule.
REQ-012 vid_addr  in  AW  video word address.
REQ-013 vid_ack  out  1  one-cycle completion pulse.
REQ-014 vid_dout  out  DW  video read data, valid with vid_ack.
REQ-015 ram_ce, ram_oce, ram_wre  out  1 each  single-port RAM clock enable, output enable, write enable.
REQ-016 ram_ad  out  AW, ram_din  out  DW, ram_dout  in  DW  RAM address, write data, read data (bypass read mode: data valid after the enabling edge).

Function
REQ-017 The block SHALL implement FSM states IDLE, ISSUE, WAIT, ACK; all outputs registered.
REQ-018 IDLE: no request -> stay IDLE; one or more requests -> choose grant, load ram_* registers, go ISSUE.
REQ-019 Arbitration SHALL be round-robin: both requesting -> grant the requester not granted last; single requester always granted; last-grant pointer resets to VID, so CPU wins the first tie.
REQ-020 ISSUE (1 cycle): ram_ce=1, ram_ad = granted address; ram_wre = cpu_we for CPU grant, 0 for video grant; ram_din = cpu_din on CPU write, else unchanged.
REQ-021 WAIT (1 cycle): ram_ce=0, ram_wre=0; on exit edge capture ram_dout into the granted requester's dout register, only for reads.
REQ-022 ACK (1 cycle): pulse the granted requester's ack; other ack stays 0; requests not sampled; next state IDLE.
REQ-023 Latency: request sampled at edge E0 -> ack high in the cycle after edge E2; one access per 4 cycles max.
REQ-024 cpu_dout SHALL NOT change on CPU writes; each dout holds its value until its next read completion.
REQ-025 ram_oce SHALL be tied to 1; ram_wre SHALL never be 1 outside ISSUE.
REQ-026 Requester SHALL drop req at the edge ending its ack cycle; req still high in the following IDLE is a new request.
REQ-027 Request deasserted during ISSUE/WAIT: access still completes and ack still pulses.
REQ-028 Request inputs SHALL be sampled only in IDLE; address/data changes after grant are ignored (latched at grant).
REQ-029 cpu_ack and vid_ack SHALL never be high in the same cycle.

Reset
REQ-030 On reset: state IDLE; cpu_ack, vid_ack, ram_ce, ram_wre = 0; ram_oce = 1; ram_ad, ram_din, cpu_dout, vid_dout = 0; pointer = VID.
REQ-031 Reset asserted in any state SHALL abort the access at the next edge; no ack is issued; a write in ISSUE may or may not have completed (unspecified).

Verification
REQ-032 CPU write addr 0x05 data 0xA7, then CPU read 0x05 -> ram_wre=1 for one ISSUE cycle; read returns cpu_dout=0xA7 with cpu_ack 3 cycles after request sampled.
REQ-033 cpu_req and vid_req both high from reset, held continuously -> grants alternate CPU, VID, CPU, VID; acks never overlap.
REQ-034 vid_req alone, addr 0x3F holding 0x5C -> vid_ack pulse with vid_dout=0x5C; cpu_ack stays 0, cpu_dout unchanged.
REQ-035 cpu_req dropped during WAIT -> cpu_ack still pulses once; FSM returns IDLE.
REQ-036 Reset asserted during WAIT of a VID read -> no vid_ack; all outputs at reset values next cycle; next tie grants CPU.
REQ-037 CPU write 0x11 to 0x00 while vid reads 0x00 concurrently -> vid_dout reflects grant order (old value if VID granted first, 0x11 otherwise).
